// File: rtl/mandel_host_link_if.sv
// Host-side control and result bus of the Mandelbrot UART link.
// The master drives frame parameters and start; the slave returns pixel results and status.
interface mandel_host_link_if;
  logic        start;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] cxs;
  logic [15:0] cys;
  logic [15:0] dcx;
  logic [15:0] dcy;
  logic        pix_valid;
  logic [7:0]  px_out;
  logic [7:0]  py_out;
  logic [7:0]  pix_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        err_frame;

  modport master (
    output start, pix_x, pix_y, cxs, cys, dcx, dcy,
    input  pix_valid, px_out, py_out, pix_data, busy, done, err, err_frame
  );

  modport slave (
    input  start, pix_x, pix_y, cxs, cys, dcx, dcy,
    output pix_valid, px_out, py_out, pix_data, busy, done, err, err_frame
  );
endinterface

// File: rtl/mandel_host_link.sv
// Host end of the Mandelbrot engine UART link: sends the 10-byte parameter frame,
// then collects pix_x*pix_y iteration bytes and tags each with its pixel coordinates.
//   state  | meaning
//   S_IDLE | waiting for start, parameter check
//   S_SEND | shifting the parameter frame out on txd
//   S_RECV | collecting result bytes, timeout armed
//   S_DONE | one-cycle done pulse, then back to idle
module mandel_host_link #(
  parameter int DIV         = 26,
  parameter int TIMEOUT_CYC = 2400000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd_i,
  output logic              txd_o,
  mandel_host_link_if.slave host
);
  localparam int CW = $clog2(DIV);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] BIT_TOP = CW'(DIV - 1);
  localparam logic [CW-1:0] SMP_A   = CW'(5);
  localparam logic [CW-1:0] SMP_B   = CW'(12);
  localparam logic [CW-1:0] SMP_C   = CW'(19);
  localparam logic [TW-1:0] TMO_TOP = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_DONE} state_t;

  state_t        state_q;
  logic [7:0]    pix_x_q, pix_y_q, px_q, py_q;
  logic [71:0]   frame_q;
  logic [7:0]    tx_sh_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q, tx_byte_q;
  logic          txd_q;
  logic [TW-1:0] tmo_q;
  logic          pv_q, done_q, err_q, ferr_q, busy_q;
  logic [7:0]    px_out_q, py_out_q, data_q;

  logic          rx_s1_q, rx_s2_q;
  logic          rx_act_q, rx_act_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic          rx_va_q, rx_va_d, rx_vb_q, rx_vb_d;
  logic          rx_stop_q, rx_stop_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_maj;
  logic          rx_done;

  assign rx_maj = (rx_va_q & rx_vb_q) | (rx_va_q & rx_s2_q) | (rx_vb_q & rx_s2_q);

  always_comb begin
    rx_act_d  = rx_act_q;
    rx_cnt_d  = rx_cnt_q;
    rx_bit_d  = rx_bit_q;
    rx_va_d   = rx_va_q;
    rx_vb_d   = rx_vb_q;
    rx_stop_d = rx_stop_q;
    rx_sh_d   = rx_sh_q;
    rx_done   = 1'b0;
    if (!rx_act_q) begin
      if (!rx_s2_q) begin
        rx_act_d = 1'b1;
        rx_cnt_d = '0;
        rx_bit_d = 4'd0;
      end
    end else begin
      if (rx_cnt_q == SMP_A) rx_va_d = rx_s2_q;
      if (rx_cnt_q == SMP_B) rx_vb_d = rx_s2_q;
      if (rx_cnt_q == SMP_C) begin
        if (rx_bit_q == 4'd9)      rx_stop_d = rx_maj;
        else if (rx_bit_q != 4'd0) rx_sh_d   = {rx_maj, rx_sh_q[7:1]};
      end
      if (rx_cnt_q == BIT_TOP) begin
        rx_cnt_d = '0;
        if (rx_bit_q == 4'd9) begin
          rx_act_d = 1'b0;
          rx_done  = 1'b1;
        end else begin
          rx_bit_d = rx_bit_q + 4'd1;
        end
      end else begin
        rx_cnt_d = rx_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_act_q  <= 1'b0;
      rx_cnt_q  <= '0;
      rx_bit_q  <= 4'd0;
      rx_va_q   <= 1'b1;
      rx_vb_q   <= 1'b1;
      rx_stop_q <= 1'b1;
      rx_sh_q   <= 8'h00;
    end else begin
      rx_s1_q   <= rxd_i;
      rx_s2_q   <= rx_s1_q;
      rx_act_q  <= rx_act_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_va_q   <= rx_va_d;
      rx_vb_q   <= rx_vb_d;
      rx_stop_q <= rx_stop_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pix_x_q   <= 8'h00;
      pix_y_q   <= 8'h00;
      px_q      <= 8'h00;
      py_q      <= 8'h00;
      frame_q   <= '0;
      tx_sh_q   <= 8'h00;
      tx_cnt_q  <= '0;
      tx_bit_q  <= 4'd0;
      tx_byte_q <= 4'd0;
      txd_q     <= 1'b1;
      tmo_q     <= '0;
      pv_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
      px_out_q  <= 8'h00;
      py_out_q  <= 8'h00;
      data_q    <= 8'h00;
    end else begin
      pv_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (host.start) begin
            if (host.pix_x == 8'd0 || host.pix_y == 8'd0) begin
              err_q <= 1'b1;
            end else begin
              state_q   <= S_SEND;
              busy_q    <= 1'b1;
              pix_x_q   <= host.pix_x;
              pix_y_q   <= host.pix_y;
              frame_q   <= {host.pix_y, host.cxs, host.cys, host.dcx, host.dcy};
              tx_sh_q   <= host.pix_x;
              txd_q     <= 1'b0;
              tx_bit_q  <= 4'd0;
              tx_byte_q <= 4'd0;
              tx_cnt_q  <= BIT_TOP;
            end
          end
        end
        S_SEND: begin
          if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
          end else begin
            tx_cnt_q <= BIT_TOP;
            // bit 0 is the start bit, 1..8 data, 9 stop
            if (tx_bit_q < 4'd8) begin
              txd_q    <= tx_sh_q[0];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_bit_q <= tx_bit_q + 4'd1;
            end else if (tx_bit_q == 4'd8) begin
              txd_q    <= 1'b1;
              tx_bit_q <= 4'd9;
            end else if (tx_byte_q == 4'd9) begin
              state_q <= S_RECV;
              tmo_q   <= TMO_TOP;
              px_q    <= 8'h00;
              py_q    <= 8'h00;
            end else begin
              tx_byte_q <= tx_byte_q + 4'd1;
              tx_bit_q  <= 4'd0;
              txd_q     <= 1'b0;
              tx_sh_q   <= frame_q[71:64];
              frame_q   <= {frame_q[63:0], 8'h00};
            end
          end
        end
        S_RECV: begin
          if (rx_done) begin
            pv_q     <= 1'b1;
            ferr_q   <= ~rx_stop_q;
            px_out_q <= px_q;
            py_out_q <= py_q;
            data_q   <= rx_sh_q;
            tmo_q    <= TMO_TOP;
            if (py_q == pix_y_q - 8'd1) begin
              py_q <= 8'h00;
              if (px_q == pix_x_q - 8'd1) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                px_q <= px_q + 8'd1;
              end
            end else begin
              py_q <= py_q + 8'd1;
            end
          end else if (tmo_q == '0) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign txd_o          = txd_q;
  assign host.pix_valid = pv_q;
  assign host.px_out    = px_out_q;
  assign host.py_out    = py_out_q;
  assign host.pix_data  = data_q;
  assign host.busy      = busy_q;
  assign host.done      = done_q;
  assign host.err       = err_q;
  assign host.err_frame = ferr_q;
endmodule

// File: tb/tb_mandel_host_link.sv
// Scoreboard bench for mandel_host_link: a UART monitor checks the parameter frame,
// an engine model returns result bytes, and a pixel monitor compares against coordinates k/pix_y, k%pix_y.
module tb_mandel_host_link;
  localparam int DIV = 26;
  localparam int TMO = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd;

  mandel_host_link_if hif();

  mandel_host_link #(.DIV(DIV), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd_i (rxd),
    .txd_o (txd),
    .host  (hif.slave)
  );

  always #5 clk = ~clk;

  typedef struct { int px; int py; int data; int ferr; } pix_t;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     tx_q[$];
  pix_t   pix_q[$];
  pix_t   e;
  int     err_cnt = 0;
  int     done_cnt = 0;
  longint err_cyc = 0, pv_cyc = 0, busy_rise = 0;
  logic   busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // pixel / status monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (hif.pix_valid) begin
        pv_cyc = cyc;
        if (pix_q.size() == 0) chk("pix_unexpected", 1, 0);
        else begin
          e = pix_q.pop_front();
          chk("px_out", hif.px_out, e.px);
          chk("py_out", hif.py_out, e.py);
          chk("pix_data", hif.pix_data, e.data);
          chk("err_frame", hif.err_frame, e.ferr);
        end
      end else if (hif.err_frame) chk("err_frame_without_valid", 1, 0);
      if (hif.err) begin err_cnt++; err_cyc = cyc; end
      if (hif.done) done_cnt++;
      if (hif.busy && !busy_prev) busy_rise = cyc;
      busy_prev = hif.busy;
    end
  end

  // UART monitor on txd
  initial begin : txmon
    int idx;
    longint st, prev;
    logic [7:0] b;
    logic stp, ab;
    idx = 0; prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin idx = 0; continue; end
      if (txd) continue;
      st = cyc; ab = 1'b0; b = 8'h00; stp = 1'b0;
      repeat (DIV/2) begin @(negedge clk); ab = ab | rst; end
      for (int i = 0; i < 9; i++) begin
        repeat (DIV) begin @(negedge clk); ab = ab | rst; end
        if (i < 8) b[i] = txd; else stp = txd;
      end
      if (ab) begin idx = 0; continue; end
      if (tx_q.size() == 0) chk("tx_unexpected", 1, 0);
      else chk("tx_byte", b, tx_q.pop_front());
      chk("tx_stop", stp, 1);
      if (idx == 0) chk("tx_first_timing", st, busy_rise);
      else chk("tx_spacing", st - prev, 10*DIV);
      prev = st;
      idx = (idx == 9) ? 0 : idx + 1;
    end
  end

  task automatic send_bit(logic v, bit glitch);
    for (int c = 0; c < DIV; c++) begin
      rxd = (glitch && c >= 12 && c <= 16) ? ~v : v;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(logic [7:0] d, bit bad_stop, bit glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch && i == 3);
    send_bit(~bad_stop, 1'b0);
    rxd = 1'b1;
  endtask

  task automatic start_frame(int nx, int ny, logic [15:0] cx, logic [15:0] cy,
                             logic [15:0] dx, logic [15:0] dy);
    hif.pix_x = 8'(nx); hif.pix_y = 8'(ny);
    hif.cxs = cx; hif.cys = cy; hif.dcx = dx; hif.dcy = dy;
    tx_q.push_back(nx); tx_q.push_back(ny);
    tx_q.push_back(int'(cx[15:8])); tx_q.push_back(int'(cx[7:0]));
    tx_q.push_back(int'(cy[15:8])); tx_q.push_back(int'(cy[7:0]));
    tx_q.push_back(int'(dx[15:8])); tx_q.push_back(int'(dx[7:0]));
    tx_q.push_back(int'(dy[15:8])); tx_q.push_back(int'(dy[7:0]));
    hif.start = 1'b1;
    @(posedge clk); #1;
    hif.start = 1'b0;
    chk("busy_next_cycle", hif.busy, 1);
    chk("txd_start_bit", txd, 0);
  endtask

  task automatic wait_recv();
    int n = 0;
    while (tx_q.size() != 0 && n < 4000) begin @(posedge clk); n++; end
    #1;
    chk("tx_drain", tx_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_in_recv", hif.busy, 1);
  endtask

  task automatic send_results(int nx, int ny, int nbytes, bit fixed, bit allow_bad);
    for (int k = 0; k < nbytes; k++) begin
      logic [7:0] d;
      bit bad, gl;
      d   = fixed ? 8'(10 + k) : 8'($urandom);
      bad = allow_bad && ($urandom_range(0, 3) == 0);
      gl  = allow_bad && ($urandom_range(0, 1) == 0);
      pix_q.push_back('{k / ny, k % ny, int'(d), int'(bad)});
      send_byte(d, bad, gl);
    end
  endtask

  task automatic wait_done(int d0);
    int n = 0;
    while (done_cnt == d0 && n < 200) begin @(posedge clk); n++; end
    repeat (5) @(posedge clk);
    #1;
    chk("done_pulse_count", done_cnt - d0, 1);
    chk("busy_after_done", hif.busy, 0);
    chk("pix_queue_drained", pix_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, e0, nx, ny;
    bit hi;
    hif.start = 1'b0; hif.pix_x = 8'h00; hif.pix_y = 8'h00;
    hif.cxs = 16'h0; hif.cys = 16'h0; hif.dcx = 16'h0; hif.dcy = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_busy", hif.busy, 0);
    chk("rst_pix_valid", hif.pix_valid, 0);
    chk("rst_done", hif.done, 0);
    chk("rst_err", hif.err, 0);
    chk("rst_err_frame", hif.err_frame, 0);
    chk("rst_px_out", hif.px_out, 0);
    chk("rst_py_out", hif.py_out, 0);
    chk("rst_pix_data", hif.pix_data, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // directed frame 2x3 with results 10..15
    d0 = done_cnt;
    start_frame(2, 3, 16'hE000, 16'hF000, 16'h0040, 16'h0040);
    wait_recv();
    send_results(2, 3, 6, 1'b1, 1'b0);
    wait_done(d0);

    // rejected starts
    for (int r = 0; r < 2; r++) begin
      hif.pix_x = (r == 0) ? 8'd4 : 8'd0;
      hif.pix_y = (r == 0) ? 8'd0 : 8'd5;
      hif.start = 1'b1;
      @(posedge clk); #1;
      hif.start = 1'b0;
      chk("reject_err_pulse", hif.err, 1);
      chk("reject_busy", hif.busy, 0);
      hi = 1'b1;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk); #1;
        hi = hi & txd & ~hif.busy;
        if (c == 0) chk("reject_err_single", hif.err, 0);
      end
      chk("reject_txd_idle", hi, 1);
    end

    // timeout after one result byte
    e0 = err_cnt; d0 = done_cnt;
    start_frame(2, 3, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    wait_recv();
    send_results(2, 3, 1, 1'b0, 1'b0);
    for (int n = 0; n < TMO + 1000 && err_cnt == e0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("timeout_err_count", err_cnt - e0, 1);
    chk("timeout_latency", err_cyc - pv_cyc, TMO);
    chk("timeout_busy", hif.busy, 0);
    chk("timeout_no_done", done_cnt - d0, 0);

    // glitch at sample 12 plus bad stop bit
    d0 = done_cnt;
    start_frame(1, 2, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    wait_recv();
    pix_q.push_back('{0, 0, 'hA5, 1});
    send_byte(8'hA5, 1'b1, 1'b1);
    pix_q.push_back('{0, 1, 'h3C, 0});
    send_byte(8'h3C, 1'b0, 1'b1);
    wait_done(d0);

    // reset mid-send, restart, and a start while busy
    start_frame(3, 2, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    repeat (400) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_txd", txd, 1);
    chk("rst_async_busy", hif.busy, 0);
    tx_q.delete(); pix_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held_txd", txd, 1);
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    e0 = err_cnt; d0 = done_cnt;
    start_frame(2, 2, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    repeat (100) @(posedge clk);
    #1;
    hif.pix_x = 8'd7; hif.pix_y = 8'd0; hif.cxs = 16'hFFFF;
    hif.start = 1'b1;
    @(posedge clk); #1;
    hif.start = 1'b0;
    wait_recv();
    send_results(2, 2, 4, 1'b0, 1'b0);
    wait_done(d0);
    chk("busy_start_ignored", err_cnt - e0, 0);

    // randomized frames
    for (int f = 0; f < 3; f++) begin
      nx = $urandom_range(1, 3);
      ny = $urandom_range(1, 3);
      d0 = done_cnt;
      start_frame(nx, ny, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      wait_recv();
      send_results(nx, ny, nx*ny, 1'b0, 1'b1);
      wait_done(d0);
    end

    repeat (50) @(posedge clk);
    #1;
    chk("final_tx_queue", tx_q.size(), 0);
    chk("final_txd_idle", txd, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
